// File: rtl/mul_issue_ctrl.sv
// Issue/retire control for the two-stage multiplier plus write-port arbitration against ALU writeback.
// Latency: an op accepted on edge N retires on edge N+2 at the earliest; arbitration and dep_stall are combinational.
// Backpressure: an ALU win holds the multiplier pipe and drops issue_ready; starvation cap forces a multiplier win.
module mul_issue_ctrl #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic [4:0]      issue_rd,
  input  logic [4:0]      dec_ra,
  input  logic [4:0]      dec_rb,
  output logic            dep_stall,
  input  logic            flush,
  output logic            mul_valid,
  output logic            mul_hold,
  input  logic [XLEN-1:0] mul_result,
  input  logic            alu_wb_valid,
  input  logic [4:0]      alu_wb_rd,
  input  logic [XLEN-1:0] alu_wb_value,
  output logic            alu_wb_ready,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            busy
);

  localparam int              CW   = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0]   SMAX = CW'(STARVE_MAX);

  logic          s1_v, s2_v;
  logic [4:0]    s1_rd, s2_rd;
  logic [CW-1:0] starve_cnt;
  logic          alu_wins, mul_wins;
  logic          s1_hit, s2_hit;

  // Write-port arbitration: a pending result loses to the ALU until the starvation cap is reached.
  // A flush cycle hands the port to the ALU unconditionally so the doomed result is never written.
  always_comb begin
    alu_wins = 1'b0;
    mul_wins = 1'b0;
    if (s2_v && !flush) begin
      alu_wins = alu_wb_valid && (starve_cnt < SMAX);
      mul_wins = !alu_wins;
    end
  end

  assign mul_hold     = alu_wins;
  assign issue_ready  = ~alu_wins & ~flush;
  assign mul_valid    = issue_valid & issue_ready;
  assign alu_wb_ready = ~mul_wins;

  // Register-file port mux; x0 multiply results retire without a write, and reset suppresses any write.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = alu_wb_rd;
    rf_wdata = alu_wb_value;
    if (mul_wins) begin
      rf_we    = (s2_rd != 5'd0);
      rf_waddr = s2_rd;
      rf_wdata = mul_result;
    end else begin
      rf_we    = alu_wb_valid;
    end
    if (!rst) rf_we = 1'b0;
  end

  // RAW hazard against any live, nonzero in-flight destination.
  always_comb begin
    s1_hit    = s1_v && (s1_rd != 5'd0) && ((s1_rd == dec_ra) || (s1_rd == dec_rb));
    s2_hit    = s2_v && (s2_rd != 5'd0) && ((s2_rd == dec_ra) || (s2_rd == dec_rb));
    dep_stall = s1_hit | s2_hit;
  end

  assign busy = s1_v | s2_v;

  // Tag pipeline and starvation counter; tags freeze while the ALU holds the port.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_v       <= 1'b0;
      s2_v       <= 1'b0;
      s1_rd      <= 5'd0;
      s2_rd      <= 5'd0;
      starve_cnt <= '0;
    end else if (flush) begin
      s1_v       <= 1'b0;
      s2_v       <= 1'b0;
      starve_cnt <= '0;
    end else begin
      if (!mul_hold) begin
        s2_v  <= s1_v;
        s2_rd <= s1_rd;
        s1_v  <= mul_valid;
        if (mul_valid) s1_rd <= issue_rd;
      end
      // alu_wins already implies starve_cnt is below the cap, so the increment saturates.
      if (alu_wins) starve_cnt <= starve_cnt + 1'b1;
      else          starve_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Bench for mul_issue_ctrl: directed scenarios plus a random phase checked by an in-order scoreboard.
// A behavioural two-stage multiplier honouring mul_hold supplies mul_result.
// Each directed step drives inputs just after posedge and samples outputs on negedge.
module tb_mul_issue_ctrl;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            issue_valid, issue_ready;
  logic [4:0]      issue_rd, dec_ra, dec_rb;
  logic            dep_stall, flush, mul_valid, mul_hold;
  logic [XLEN-1:0] mul_result;
  logic            alu_wb_valid, alu_wb_ready;
  logic [4:0]      alu_wb_rd;
  logic [XLEN-1:0] alu_wb_value;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            busy;

  logic [XLEN-1:0] op_a, op_b;
  logic [XLEN-1:0] m1, m2;
  logic [36:0]     sb_q[$];
  logic [36:0]     sb_e;
  int              vec_cnt = 0;
  int              err_cnt = 0;

  mul_issue_ctrl #(.XLEN(XLEN), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_rd(issue_rd),
    .dec_ra(dec_ra), .dec_rb(dec_rb), .dep_stall(dep_stall),
    .flush(flush), .mul_valid(mul_valid), .mul_hold(mul_hold), .mul_result(mul_result),
    .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_value(alu_wb_value),
    .alu_wb_ready(alu_wb_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // External multiplier: operands captured with Valid, both stages frozen by hold.
  always @(posedge clk) begin
    if (!mul_hold) begin
      m2 <= m1;
      if (mul_valid) m1 <= op_a * op_b;
    end
  end
  assign mul_result = m2;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Scoreboard: pushes on accept, pops on each multiplier write, checks every ALU grant.
  always @(negedge clk) begin
    if (!rst) begin
      sb_q.delete();
    end else begin
      if (rf_we && !alu_wb_ready) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_wr", 64'd1, 64'd0);
        end else begin
          sb_e = sb_q.pop_front();
          chk("sb_waddr", 64'(rf_waddr), 64'(sb_e[36:32]));
          chk("sb_wdata", 64'(rf_wdata), 64'(sb_e[31:0]));
        end
      end
      if (alu_wb_valid && alu_wb_ready) begin
        chk("alu_we", 64'(rf_we), 64'd1);
        chk("alu_waddr", 64'(rf_waddr), 64'(alu_wb_rd));
        chk("alu_wdata", 64'(rf_wdata), 64'(alu_wb_value));
      end
      if (flush) sb_q.delete();
      else if (issue_valid && issue_ready && issue_rd != 5'd0)
        sb_q.push_back({issue_rd, op_a * op_b});
    end
  end

  initial begin
    rst = 1'b0; issue_valid = 1'b1; issue_rd = 5'd4; dec_ra = 5'd0; dec_rb = 5'd0;
    flush = 1'b0; alu_wb_valid = 1'b0; alu_wb_rd = 5'd0; alu_wb_value = '0;
    op_a = 32'd1; op_b = 32'd1;

    // Reset held two cycles with issue_valid high.
    mid(); chk("rst_we0", 64'(rf_we), 0); chk("rst_busy0", 64'(busy), 0);
    nxt(); mid(); chk("rst_we1", 64'(rf_we), 0); chk("rst_busy1", 64'(busy), 0);
    nxt(); rst = 1'b1; issue_valid = 1'b0;
    mid(); chk("idle_busy", 64'(busy), 0); chk("idle_we", 64'(rf_we), 0);
    chk("idle_ready", 64'(issue_ready), 1); chk("idle_dep", 64'(dep_stall), 0);
    chk("idle_hold", 64'(mul_hold), 0); chk("idle_aluok", 64'(alu_wb_ready), 1);

    // Single MUL rd=5, 2*3.
    nxt(); issue_valid = 1'b1; issue_rd = 5'd5; op_a = 32'd2; op_b = 32'd3;
    mid(); chk("one_ready", 64'(issue_ready), 1);
    nxt(); issue_valid = 1'b0;
    mid(); chk("one_busy1", 64'(busy), 1); chk("one_we1", 64'(rf_we), 0);
    nxt();
    mid(); chk("one_busy2", 64'(busy), 1); chk("one_we2", 64'(rf_we), 1);
    chk("one_addr", 64'(rf_waddr), 5); chk("one_data", 64'(rf_wdata), 6);
    nxt();
    mid(); chk("one_busy3", 64'(busy), 0); chk("one_we3", 64'(rf_we), 0);

    // Back-to-back rd=1,2,3 with a hazard probe on r2.
    nxt(); issue_valid = 1'b1; issue_rd = 5'd1; op_a = 32'd3; op_b = 32'd4;
    mid();
    nxt(); issue_rd = 5'd2; op_a = 32'd5; op_b = 32'd6;
    mid();
    nxt(); issue_rd = 5'd3; op_a = 32'd7; op_b = 32'd8; dec_ra = 5'd2;
    mid(); chk("b2b_we1", 64'(rf_we), 1); chk("b2b_a1", 64'(rf_waddr), 1);
    chk("b2b_d1", 64'(rf_wdata), 12); chk("b2b_dep_s1", 64'(dep_stall), 1);
    nxt(); issue_valid = 1'b0;
    mid(); chk("b2b_we2", 64'(rf_we), 1); chk("b2b_a2", 64'(rf_waddr), 2);
    chk("b2b_d2", 64'(rf_wdata), 30); chk("b2b_dep_s2", 64'(dep_stall), 1);
    nxt();
    mid(); chk("b2b_we3", 64'(rf_we), 1); chk("b2b_a3", 64'(rf_waddr), 3);
    chk("b2b_d3", 64'(rf_wdata), 56); chk("b2b_dep_gone", 64'(dep_stall), 0);
    nxt();
    mid(); chk("b2b_busy", 64'(busy), 0);
    dec_ra = 5'd0;

    // Contention: ALU wins four times, then the multiplier is forced through.
    nxt(); issue_valid = 1'b1; issue_rd = 5'd9; op_a = 32'd4; op_b = 32'd5;
    mid();
    nxt(); issue_rd = 5'd10; op_a = 32'd6; op_b = 32'd7;
    mid();
    nxt(); issue_valid = 1'b0; alu_wb_valid = 1'b1; alu_wb_rd = 5'd7; alu_wb_value = 32'hAA;
    for (int i = 0; i < 4; i++) begin
      mid();
      chk("cont_aluok", 64'(alu_wb_ready), 1); chk("cont_hold", 64'(mul_hold), 1);
      chk("cont_noissue", 64'(issue_ready), 0); chk("cont_addr", 64'(rf_waddr), 7);
      nxt();
    end
    mid(); chk("starve_aluok", 64'(alu_wb_ready), 0); chk("starve_hold", 64'(mul_hold), 0);
    chk("starve_we", 64'(rf_we), 1); chk("starve_addr", 64'(rf_waddr), 9);
    chk("starve_data", 64'(rf_wdata), 20);
    nxt();
    mid(); chk("restart_aluok", 64'(alu_wb_ready), 1); chk("restart_hold", 64'(mul_hold), 1);
    nxt(); alu_wb_valid = 1'b0;
    mid(); chk("cont2_addr", 64'(rf_waddr), 10); chk("cont2_data", 64'(rf_wdata), 42);
    nxt();
    mid(); chk("cont_busy", 64'(busy), 0);

    // Flush with both stages occupied and a new op offered.
    nxt(); issue_valid = 1'b1; issue_rd = 5'd12; op_a = 32'd2; op_b = 32'd2;
    mid();
    nxt(); issue_rd = 5'd13;
    mid();
    nxt(); flush = 1'b1; issue_rd = 5'd14;
    mid(); chk("fl_ready", 64'(issue_ready), 0); chk("fl_we", 64'(rf_we), 0);
    chk("fl_hold", 64'(mul_hold), 0); chk("fl_aluok", 64'(alu_wb_ready), 1);
    chk("fl_mulv", 64'(mul_valid), 0);
    nxt(); flush = 1'b0; issue_valid = 1'b0;
    mid(); chk("fl_busy", 64'(busy), 0); chk("fl_we1", 64'(rf_we), 0);
    nxt();
    mid(); chk("fl_we2", 64'(rf_we), 0);

    // x0 destination.
    nxt(); issue_valid = 1'b1; issue_rd = 5'd0; op_a = 32'd9; op_b = 32'd9;
    mid();
    nxt(); issue_valid = 1'b0;
    mid(); chk("x0_busy1", 64'(busy), 1); chk("x0_dep1", 64'(dep_stall), 0);
    nxt();
    mid(); chk("x0_busy2", 64'(busy), 1); chk("x0_we", 64'(rf_we), 0);
    chk("x0_dep2", 64'(dep_stall), 0);
    nxt();
    mid(); chk("x0_busy3", 64'(busy), 0);

    // Reset while a result is pending in stage 2.
    nxt(); issue_valid = 1'b1; issue_rd = 5'd15; op_a = 32'd3; op_b = 32'd3;
    mid();
    nxt(); issue_valid = 1'b0;
    mid();
    nxt(); rst = 1'b0;
    mid(); chk("rmid_we", 64'(rf_we), 0);
    nxt(); rst = 1'b1;
    mid(); chk("rmid_busy", 64'(busy), 0); chk("rmid_we1", 64'(rf_we), 0);
    nxt();
    mid(); chk("rmid_we2", 64'(rf_we), 0);

    // Random traffic against the scoreboard.
    for (int i = 0; i < 400; i++) begin
      nxt();
      issue_valid  = 1'($urandom_range(0, 1));
      issue_rd     = 5'($urandom_range(0, 31));
      op_a         = $urandom;
      op_b         = $urandom;
      alu_wb_valid = ($urandom_range(0, 3) != 0);
      alu_wb_rd    = 5'($urandom_range(0, 31));
      alu_wb_value = $urandom;
      dec_ra       = 5'($urandom_range(0, 31));
      dec_rb       = 5'($urandom_range(0, 31));
      mid();
    end
    nxt(); issue_valid = 1'b0; alu_wb_valid = 1'b0;
    repeat (6) begin
      mid();
      nxt();
    end
    mid();
    chk("sb_drain", 64'(sb_q.size()), 0);
    chk("end_busy", 64'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
